// File: rtl/valid_ack_pkg.sv
// Shared constants and helpers for the valid/ack register pipeline.
// Payload width and depth defaults live here; the count width is derived from depth.
package valid_ack_pkg;

    localparam int DEFAULT_DATA_W = 3;
    localparam int DEFAULT_DEPTH  = 4;

    typedef logic [DEFAULT_DATA_W-1:0] payload_t;

    // Bits needed to represent occupancy 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/valid_ack_stage.sv
// One register slot of the valid/ack pipeline: loads whenever it is empty or
// the slot downstream of it is ready, and collapses bubbles while stalled.
module valid_ack_stage
    import valid_ack_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rdy_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              rdy_o
);

    // An empty slot always accepts, even when everything downstream is stalled.
    assign rdy_o = !valid_o || rdy_i;

    // NOTE: state registers use non-blocking assignments so every slot samples
    // its neighbour's pre-edge value and the chain shifts by exactly one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            // NOTE: the payload register is reset as well so data_out reads 0
            // out of reset instead of X.
            data_o  <= '0;
        end else if (flush) begin
            valid_o <= 1'b0;
        end else if (rdy_o) begin
            valid_o <= valid_i;
            if (valid_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/valid_ack_pipe.sv
// DEPTH-slot valid/ack pipeline with synchronous flush, occupancy count and
// full/empty flags. The ready path is combinational from ack_in to ack_out.
module valid_ack_pipe
    import valid_ack_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic [DATA_W-1:0]           data_in,
    output logic                        ack_out,
    output logic                        valid_out,
    output logic [DATA_W-1:0]           data_out,
    input  logic                        ack_in,
    input  logic                        flush,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic in_fire;
    logic out_fire;

    // Each slot gets its own signals so the ready chain is not one self-referencing vector.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic              v_in;
        logic [DATA_W-1:0] d_in;
        logic              rdy_nxt;
        logic              v_q;
        logic [DATA_W-1:0] d_q;
        logic              rdy;

        if (k == 0) begin : g_first
            assign v_in = valid_in;
            assign d_in = data_in;
        end else begin : g_mid
            assign v_in = g_stage[k-1].v_q;
            assign d_in = g_stage[k-1].d_q;
        end

        if (k == DEPTH - 1) begin : g_last
            assign rdy_nxt = ack_in;
        end else begin : g_inner
            assign rdy_nxt = g_stage[k+1].rdy;
        end

        valid_ack_stage #(
            .DATA_W (DATA_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .valid_i (v_in),
            .data_i  (d_in),
            .rdy_i   (rdy_nxt),
            .valid_o (v_q),
            .data_o  (d_q),
            .rdy_o   (rdy)
        );
    end

    // Flush blocks both handshakes in the cycle it is asserted.
    assign ack_out   = g_stage[0].rdy && !flush;
    assign valid_out = g_stage[DEPTH-1].v_q && !flush;
    assign data_out  = g_stage[DEPTH-1].d_q;

    assign in_fire  = valid_in && ack_out;
    assign out_fire = valid_out && ack_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: tb/tb_valid_ack_pipe.sv
// Directed bench for valid_ack_pipe at DATA_W=3, DEPTH=4: reset, streaming,
// back-pressure, bubbles, flush and asynchronous reset mid-stream.
module tb_valid_ack_pipe;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic [2:0] data_in;
    logic       ack_out;
    logic       valid_out;
    logic [2:0] data_out;
    logic       ack_in;
    logic       flush;
    logic [2:0] count;
    logic       full;
    logic       empty;

    int checks   = 0;
    int failures = 0;

    valid_ack_pipe #(
        .DATA_W (3),
        .DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ack_in    (ack_in),
        .flush     (flush),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic vi, input logic [2:0] di, input logic ai, input logic fl);
        valid_in = vi;
        data_in  = di;
        ack_in   = ai;
        flush    = fl;
        #1;
    endtask

    // Expected tables for the bubble test, cycles 0..8.
    logic       bub_vin [9] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
    logic [2:0] bub_din [9] = '{3, 0, 4, 5, 0, 0, 0, 0, 0};
    logic       bub_vout[9] = '{0, 0, 0, 0, 1, 0, 1, 1, 0};
    logic [2:0] bub_dout[9] = '{0, 0, 0, 0, 3, 0, 4, 5, 0};
    int         bub_cnt [9] = '{0, 1, 1, 2, 3, 2, 2, 1, 0};

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        ack_in   = 1'b0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        tick();
        drive(0, 0, 1, 0);
        check("rst_valid_out", 32'(valid_out), 0);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ack_out", 32'(ack_out), 1);

        // Streaming 1..6 with ack_in held high
        for (int n = 0; n < 11; n++) begin
            tick();
            drive(n < 6, 3'(n + 1), 1, 0);
            check("stream_ack_out", 32'(ack_out), 1);
            check("stream_valid_out", 32'(valid_out), (n >= 4 && n <= 9) ? 1 : 0);
            if (n >= 4 && n <= 9) check("stream_data_out", 32'(data_out), n - 3);
            check("stream_count", 32'(count),
                  ((n < 6) ? n : 6) - ((n > 4) ? n - 4 : 0));
        end
        check("stream_empty_end", 32'(empty), 1);

        // Back-pressure: fill while stalled, then drain with a simultaneous push
        for (int n = 0; n < 5; n++) begin
            tick();
            drive(1, 3'(n + 1), 0, 0);
            check("bp_ack_out", 32'(ack_out), (n < 4) ? 1 : 0);
            check("bp_count", 32'(count), n);
        end
        check("bp_full", 32'(full), 1);
        check("bp_valid_out", 32'(valid_out), 1);
        check("bp_data_out", 32'(data_out), 1);
        tick();
        drive(1, 5, 0, 0);
        check("bp_hold_data", 32'(data_out), 1);
        check("bp_hold_ack_out", 32'(ack_out), 0);
        check("bp_hold_count", 32'(count), 4);
        tick();
        drive(1, 5, 1, 0);
        check("bp_swap_ack_out", 32'(ack_out), 1);
        check("bp_swap_data_out", 32'(data_out), 1);
        for (int n = 0; n < 4; n++) begin
            tick();
            drive(0, 0, 1, 0);
            check("bp_drain_valid", 32'(valid_out), 1);
            check("bp_drain_data", 32'(data_out), n + 2);
            check("bp_drain_count", 32'(count), 4 - n);
        end
        tick();
        drive(0, 0, 1, 0);
        check("bp_drained_valid", 32'(valid_out), 0);
        check("bp_drained_count", 32'(count), 0);

        // Bubbles collapse and do not duplicate data
        for (int n = 0; n < 9; n++) begin
            tick();
            drive(bub_vin[n], bub_din[n], 1, 0);
            check("bub_valid_out", 32'(valid_out), 32'(bub_vout[n]));
            if (bub_vout[n]) check("bub_data_out", 32'(data_out), 32'(bub_dout[n]));
            check("bub_count", 32'(count), bub_cnt[n]);
        end

        // Flush with three items held and the last stage valid
        for (int n = 0; n < 3; n++) begin
            tick();
            drive(1, 3'(n + 1), 0, 0);
        end
        tick();
        drive(0, 0, 0, 0);
        check("fl_pre_count", 32'(count), 3);
        tick();
        drive(0, 0, 0, 0);
        check("fl_pre_valid_out", 32'(valid_out), 1);
        drive(1, 7, 1, 1);
        check("fl_ack_out", 32'(ack_out), 0);
        check("fl_valid_out", 32'(valid_out), 0);
        tick();
        drive(0, 0, 1, 0);
        check("fl_post_count", 32'(count), 0);
        check("fl_post_empty", 32'(empty), 1);
        check("fl_post_valid_out", 32'(valid_out), 0);
        for (int n = 0; n < 4; n++) begin
            tick();
            drive(0, 0, 1, 0);
            check("fl_no_leak", 32'(valid_out), 0);
        end

        // Asynchronous reset between edges with two items held
        for (int n = 0; n < 2; n++) begin
            tick();
            drive(1, 3'(n + 2), 0, 0);
        end
        repeat (3) begin
            tick();
            drive(0, 0, 0, 0);
        end
        check("ar_pre_count", 32'(count), 2);
        check("ar_pre_valid_out", 32'(valid_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_out", 32'(valid_out), 0);
        check("ar_count", 32'(count), 0);
        check("ar_empty", 32'(empty), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(1, 6, 1, 0);
        check("ar_ack_out", 32'(ack_out), 1);
        for (int n = 1; n < 4; n++) begin
            tick();
            drive(0, 0, 1, 0);
            check("ar_latency_idle", 32'(valid_out), 0);
        end
        tick();
        drive(0, 0, 1, 0);
        check("ar_new_valid", 32'(valid_out), 1);
        check("ar_new_data", 32'(data_out), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
